// File: rtl/agc_pipa_pkg.sv
// Shared types and helpers for the PIPA pulse interface.
package agc_pipa_pkg;

  typedef enum logic [1:0] {AX_X, AX_Y, AX_Z} axis_e;

  localparam int unsigned PIPA_CNT_W_DEF = 4;

  // Largest magnitude a signed pending counter of width w may hold.
  function automatic int pend_limit(input int unsigned w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/pipa_axis_channel.sv
// One PIPA axis: synchroniser, edge detect, pending counter, sample decision.
// Optional silence counter enabled by PIPA_SILENCE_DETECT_EN.
module pipa_axis_channel
  import agc_pipa_pkg::*;
#(
  parameter int unsigned CNT_W         = PIPA_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SILENCE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p_raw,
  input  logic                    m_raw,
  input  logic                    sample,
  output logic                    p_n,
  output logic                    m_n,
  output logic signed [CNT_W-1:0] pend,
  output logic                    fail_evt
);

  logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d, m_sync_q, m_sync_d;
  logic                   p_prev_q, m_prev_q;
  logic                   p_edge_q, p_edge_d, m_edge_q, m_edge_d;
  logic signed [CNT_W-1:0] pend_q, pend_d;
  logic                   p_n_q, p_n_d, m_n_q, m_n_d;
  logic signed [31:0]     cur_s, step_s, sum_s, sat_s;
  logic                   contra, ovf, sil_fail;

  always_comb begin
    p_sync_d = {p_sync_q[SYNC_STAGES-2:0], p_raw};
    m_sync_d = {m_sync_q[SYNC_STAGES-2:0], m_raw};
    p_edge_d = p_sync_q[SYNC_STAGES-1] & ~p_prev_q;
    m_edge_d = m_sync_q[SYNC_STAGES-1] & ~m_prev_q;
  end

  // Decision uses pre-update pend; edge delta and consumption are summed
  // before saturation so a simultaneous edge and sample never overflow.
  always_comb begin
    cur_s  = {{(32-CNT_W){pend_q[CNT_W-1]}}, pend_q};
    contra = p_edge_q & m_edge_q;
    step_s = '0;
    if (p_edge_q && !m_edge_q) step_s = step_s + 32'sd1;
    if (m_edge_q && !p_edge_q) step_s = step_s - 32'sd1;
    if (sample && cur_s > 0)   step_s = step_s - 32'sd1;
    if (sample && cur_s < 0)   step_s = step_s + 32'sd1;
    sum_s  = cur_s + step_s;
    sat_s  = sat_add(cur_s, step_s, pend_limit(CNT_W));
    ovf    = (sat_s != sum_s);
    pend_d = CNT_W'(sat_s);
    p_n_d  = p_n_q;
    m_n_d  = m_n_q;
    if (sample) begin
      p_n_d = ~(cur_s > 0);
      m_n_d = ~(cur_s < 0);
    end
  end

`ifdef PIPA_SILENCE_DETECT_EN
  localparam int unsigned SIL_W = $clog2(SILENCE_LIMIT + 1);
  logic [SIL_W-1:0] sil_q, sil_d;
  logic             any_edge;

  always_comb begin
    any_edge = p_edge_q | m_edge_q;
    sil_d    = sil_q;
    if (any_edge)
      sil_d = '0;
    else if (sample && sil_q != SIL_W'(SILENCE_LIMIT))
      sil_d = sil_q + 1'b1;
    sil_fail = sample & ~any_edge & (sil_d == SIL_W'(SILENCE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sil_q <= '0;
    else        sil_q <= sil_d;
  end
`else
  assign sil_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_q <= '0;
      m_sync_q <= '0;
      p_prev_q <= 1'b0;
      m_prev_q <= 1'b0;
      p_edge_q <= 1'b0;
      m_edge_q <= 1'b0;
      pend_q   <= '0;
      p_n_q    <= 1'b1;
      m_n_q    <= 1'b1;
    end else begin
      p_sync_q <= p_sync_d;
      m_sync_q <= m_sync_d;
      p_prev_q <= p_sync_q[SYNC_STAGES-1];
      m_prev_q <= m_sync_q[SYNC_STAGES-1];
      p_edge_q <= p_edge_d;
      m_edge_q <= m_edge_d;
      pend_q   <= pend_d;
      p_n_q    <= p_n_d;
      m_n_q    <= m_n_d;
    end
  end

  assign p_n      = p_n_q;
  assign m_n      = m_n_q;
  assign pend     = pend_q;
  assign fail_evt = contra | ovf | sil_fail;

endmodule

// File: rtl/pipa_pulse_interface.sv
// PIPA pulse interface: three axis channels plus sticky PIPAFL alarm.
// Silence detection is built in when PIPA_SILENCE_DETECT_EN is defined.
module pipa_pulse_interface
  import agc_pipa_pkg::*;
#(
  parameter int unsigned CNT_W         = PIPA_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SILENCE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PIPAXp_raw,
  input  logic                    PIPAXm_raw,
  input  logic                    PIPAYp_raw,
  input  logic                    PIPAYm_raw,
  input  logic                    PIPAZp_raw,
  input  logic                    PIPAZm_raw,
  input  logic                    PIPSAM,
  input  logic                    FLCLR,
  output logic                    PIPAXp_,
  output logic                    PIPAXm_,
  output logic                    PIPAYp_,
  output logic                    PIPAYm_,
  output logic                    PIPAZp_,
  output logic                    PIPAZm_,
  output logic                    PIPAFL,
  output logic signed [CNT_W-1:0] PEND_X,
  output logic signed [CNT_W-1:0] PEND_Y,
  output logic signed [CNT_W-1:0] PEND_Z
);

  logic [2:0]              raw_p, raw_m, req_p_n, req_m_n, fail_evt;
  logic signed [CNT_W-1:0] pend [3];
  logic                    pipafl_q, pipafl_d;

  assign raw_p[AX_X] = PIPAXp_raw;
  assign raw_m[AX_X] = PIPAXm_raw;
  assign raw_p[AX_Y] = PIPAYp_raw;
  assign raw_m[AX_Y] = PIPAYm_raw;
  assign raw_p[AX_Z] = PIPAZp_raw;
  assign raw_m[AX_Z] = PIPAZm_raw;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    pipa_axis_channel #(
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES),
      .SILENCE_LIMIT (SILENCE_LIMIT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .p_raw    (raw_p[a]),
      .m_raw    (raw_m[a]),
      .sample   (PIPSAM),
      .p_n      (req_p_n[a]),
      .m_n      (req_m_n[a]),
      .pend     (pend[a]),
      .fail_evt (fail_evt[a])
    );
  end

  // A fail event in the same cycle as FLCLR keeps the alarm set.
  always_comb begin
    pipafl_d = pipafl_q;
    if (FLCLR)     pipafl_d = 1'b0;
    if (|fail_evt) pipafl_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipafl_q <= 1'b0;
    else        pipafl_q <= pipafl_d;
  end

  assign PIPAXp_ = req_p_n[AX_X];
  assign PIPAXm_ = req_m_n[AX_X];
  assign PIPAYp_ = req_p_n[AX_Y];
  assign PIPAYm_ = req_m_n[AX_Y];
  assign PIPAZp_ = req_p_n[AX_Z];
  assign PIPAZm_ = req_m_n[AX_Z];
  assign PIPAFL  = pipafl_q;
  assign PEND_X  = pend[AX_X];
  assign PEND_Y  = pend[AX_Y];
  assign PEND_Z  = pend[AX_Z];

endmodule

// File: tb/tb_pipa_pulse_interface.sv
// Directed scoreboard bench for pipa_pulse_interface (CNT_W=4, L=7).
module tb_pipa_pulse_interface;

  localparam int L = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PIPAXp_raw = 1'b0, PIPAXm_raw = 1'b0, PIPAYp_raw = 1'b0;
  logic PIPAYm_raw = 1'b0, PIPAZp_raw = 1'b0, PIPAZm_raw = 1'b0;
  logic PIPSAM = 1'b0, FLCLR = 1'b0;
  logic PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_, PIPAFL;
  logic signed [3:0] PEND_X, PEND_Y, PEND_Z;

  int tests = 0;
  int fails = 0;
  int mp [3];
  logic mfl = 1'b0;
  logic [5:0] sb_q [$];

  pipa_pulse_interface #(
    .CNT_W         (4),
    .SYNC_STAGES   (2),
    .SILENCE_LIMIT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PIPAXp_raw (PIPAXp_raw),
    .PIPAXm_raw (PIPAXm_raw),
    .PIPAYp_raw (PIPAYp_raw),
    .PIPAYm_raw (PIPAYm_raw),
    .PIPAZp_raw (PIPAZp_raw),
    .PIPAZm_raw (PIPAZm_raw),
    .PIPSAM     (PIPSAM),
    .FLCLR      (FLCLR),
    .PIPAXp_    (PIPAXp_),
    .PIPAXm_    (PIPAXm_),
    .PIPAYp_    (PIPAYp_),
    .PIPAYm_    (PIPAYm_),
    .PIPAZp_    (PIPAZp_),
    .PIPAZm_    (PIPAZm_),
    .PIPAFL     (PIPAFL),
    .PEND_X     (PEND_X),
    .PEND_Y     (PEND_Y),
    .PEND_Z     (PEND_Z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_vec();
    logic [5:0] v;
    for (int a = 0; a < 3; a++) begin
      v[5-2*a] = !(mp[a] > 0);
      v[4-2*a] = !(mp[a] < 0);
    end
    return v;
  endfunction

  task automatic model_edge(input int a, input int d);
    int s;
    s = mp[a] + d;
    if (s > L) begin s = L; mfl = 1'b1; end
    if (s < -L) begin s = -L; mfl = 1'b1; end
    mp[a] = s;
  endtask

  task automatic model_consume();
    for (int a = 0; a < 3; a++) begin
      if (mp[a] > 0) mp[a] = mp[a] - 1;
      else if (mp[a] < 0) mp[a] = mp[a] + 1;
    end
  endtask

  task automatic check_pends(input string tag);
    check({tag, "_pend_x"}, PEND_X, mp[0]);
    check({tag, "_pend_y"}, PEND_Y, mp[1]);
    check({tag, "_pend_z"}, PEND_Z, mp[2]);
  endtask

  task automatic pop_check(input string tag);
    logic [5:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_req"}, {PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_}, e);
    end
  endtask

  // Back-to-back PIPSAM strobes, each scored as its own sample.
  task automatic sample_n(input string tag, input int n);
    PIPSAM = 1'b1;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_vec());
      model_consume();
      tick();
      pop_check(tag);
      check_pends(tag);
    end
    PIPSAM = 1'b0;
  endtask

  task automatic pulse(input int a, input int d);
    case ({a[1:0], d > 0})
      3'b001:  PIPAXp_raw = 1'b1;
      3'b000:  PIPAXm_raw = 1'b1;
      3'b011:  PIPAYp_raw = 1'b1;
      3'b010:  PIPAYm_raw = 1'b1;
      3'b101:  PIPAZp_raw = 1'b1;
      default: PIPAZm_raw = 1'b1;
    endcase
    repeat (4) tick();
    {PIPAXp_raw, PIPAXm_raw, PIPAYp_raw, PIPAYm_raw, PIPAZp_raw, PIPAZm_raw} = '0;
    repeat (4) tick();
    model_edge(a, d);
  endtask

  initial begin
    mp[0] = 0; mp[1] = 0; mp[2] = 0;
    repeat (3) tick();
    check("rst_req", {PIPAXp_, PIPAXm_, PIPAYp_, PIPAYm_, PIPAZp_, PIPAZm_}, 6'b111111);
    check("rst_fl", PIPAFL, 0);
    check_pends("rst");
    rst_n = 1'b1;
    tick();

    // Three +X pulses, then four consecutive samples.
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1);
      check("t1_pend_x_acc", PEND_X, i + 1);
    end
    sample_n("t1", 4);
    check("t1_fl", PIPAFL, 0);

    // Nine -Y pulses saturate at -7; alarm from the 8th edge.
    for (int i = 1; i <= 9; i++) begin
      pulse(1, -1);
      check("t2_pend_y", PEND_Y, mp[1]);
      check("t2_fl", PIPAFL, (i >= 8) ? 1 : 0);
    end
    check("t2_pend_y_sat", PEND_Y, -7);
    FLCLR = 1'b1;
    tick();
    FLCLR = 1'b0;
    mfl = 1'b0;
    check("t2_flclr", PIPAFL, 0);
    check("t2_pend_y_hold", PEND_Y, -7);

    // Contradictory Z pulses.
    PIPAZp_raw = 1'b1;
    PIPAZm_raw = 1'b1;
    repeat (4) tick();
    PIPAZp_raw = 1'b0;
    PIPAZm_raw = 1'b0;
    repeat (4) tick();
    check("t3_pend_z", PEND_Z, 0);
    check("t3_fl", PIPAFL, 1);
    FLCLR = 1'b1;
    tick();
    FLCLR = 1'b0;
    check("t3_flclr", PIPAFL, 0);

    // +X edge landing on the PIPSAM cycle with PEND_X = 1.
    pulse(0, 1);
    check("t4_pre", PEND_X, 1);
    PIPAXp_raw = 1'b1;
    repeat (3) tick();
    PIPSAM = 1'b1;
    sb_q.push_back(exp_vec());
    model_consume();
    model_edge(0, 1);
    tick();
    PIPSAM = 1'b0;
    pop_check("t4");
    check_pends("t4");
    check("t4_xp", PIPAXp_, 0);
    tick();
    PIPAXp_raw = 1'b0;
    repeat (4) tick();
    check("t4_pend_x_after", PEND_X, 1);

    // Drive X negative, sample, then assert reset mid-window.
    for (int i = 0; i < 3; i++) pulse(0, -1);
    sample_n("t5", 1);
    check("t5_xm_active", PIPAXm_, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_xm_async", PIPAXm_, 1);
    check("t5_ym_async", PIPAYm_, 1);
    check("t5_fl_async", PIPAFL, 0);
    mp[0] = 0; mp[1] = 0; mp[2] = 0;
    mfl = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_pends("t5_rel");

    // Eight silent strobes: alarm only when silence detection is built in.
    sample_n("t6", 7);
    check("t6_fl_7", PIPAFL, 0);
    sample_n("t6", 1);
`ifdef PIPA_SILENCE_DETECT_EN
    mfl = 1'b1;
`endif
    check("t6_fl_8", PIPAFL, mfl);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
